// File: rtl/inst_encoder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inst_encoder_pkg : RV32I format codes, major opcodes, opcode helper
// Revision: 1.0
// ---------------------------------------------------------------------------
package inst_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_U   = 3'd0,
    FMT_J   = 3'd1,
    FMT_B   = 3'd2,
    FMT_S   = 3'd3,
    FMT_I   = 3'd4,
    FMT_ISH = 3'd5,
    FMT_R   = 3'd6
  } fmt_e;

  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_OP     = 5'b01100;

  function automatic logic [6:0] enc_op(input logic [4:0] opcode);
    return {opcode, 2'b11};
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_encoder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inst_encoder_if : decoded-instruction request bus with valid/ready
// Revision: 1.0
// ---------------------------------------------------------------------------
interface inst_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [4:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm,
    output in_ready
  );
endinterface
`default_nettype wire

// File: rtl/inst_encoder_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inst_packer : combinational RV32I word packing and immediate range check
// Revision: 1.0
// ---------------------------------------------------------------------------
module inst_packer
  import inst_encoder_pkg::*;
(
  input  wire logic [2:0]  fmt,
  input  wire logic [4:0]  opcode,
  input  wire logic [4:0]  rd,
  input  wire logic [4:0]  rs1,
  input  wire logic [4:0]  rs2,
  input  wire logic [2:0]  funct3,
  input  wire logic [6:0]  funct7,
  input  wire logic [31:0] imm,
  output logic      [31:0] word,
  output logic             illegal
);

  logic [6:0] op;
  assign op = enc_op(opcode);

  always_comb begin
    word    = 32'd0;
    illegal = 1'b1;
    case (fmt_e'(fmt))
      FMT_U: begin
        word    = {imm[31:12], rd, op};
        illegal = (imm[11:0] != 12'd0);
      end
      FMT_J: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        illegal = imm[0] || (imm[31:21] != {11{imm[20]}});
      end
      FMT_B: begin
        word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
        illegal = imm[0] || (imm[31:13] != {19{imm[12]}});
      end
      FMT_S: begin
        word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
        illegal = (imm[31:12] != {20{imm[11]}});
      end
      FMT_I: begin
        word    = {imm[11:0], rs1, funct3, rd, op};
        illegal = (imm[31:12] != {20{imm[11]}});
      end
      FMT_ISH: begin
        // Upper shift-immediate bits come from funct7; only the shamt is taken from imm.
        word    = {funct7, imm[4:0], rs1, funct3, rd, op};
        illegal = (imm[31:5] != 27'd0);
      end
      FMT_R: begin
        word    = {funct7, rs2, rs1, funct3, rd, op};
        illegal = 1'b0;
      end
      default: begin
        word    = 32'd0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inst_encoder : encodes decoded fields and writes words to instruction RAM
// Revision: 1.0
// ---------------------------------------------------------------------------
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned BASE_ADDR = 0
) (
  input  wire logic              clk,
  input  wire logic              reset,
  inst_encoder_if.slave          req,
  input  wire logic              load_addr,
  input  wire logic [ADDR_W-1:0] addr_in,
  output logic                   mem_we,
  input  wire logic              mem_ready,
  output logic      [ADDR_W-1:0] mem_addr,
  output logic      [31:0]       mem_wdata,
  output logic                   err,
  output logic      [15:0]       words_written
);

  logic              full_q, full_d;
  logic              illegal_q, illegal_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       count_q, count_d;

  logic [31:0] pack_word;
  logic        pack_illegal;
  logic        ready;
  logic        accept;
  logic        complete;

  inst_packer u_packer (
    .fmt     (req.in_fmt),
    .opcode  (req.in_opcode),
    .rd      (req.in_rd),
    .rs1     (req.in_rs1),
    .rs2     (req.in_rs2),
    .funct3  (req.in_funct3),
    .funct7  (req.in_funct7),
    .imm     (req.in_imm),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  // An illegal entry always vacates next cycle, so it never blocks the input.
  assign ready    = !full_q || illegal_q || mem_ready;
  assign accept   = req.in_valid && ready;
  assign complete = full_q && !illegal_q && mem_ready;

  always_comb begin
    full_d    = full_q;
    illegal_d = illegal_q;
    word_d    = word_q;
    addr_d    = addr_q;
    count_d   = count_q;

    if (accept) begin
      full_d    = 1'b1;
      illegal_d = pack_illegal;
      word_d    = pack_word;
    end else if (complete || (full_q && illegal_q)) begin
      full_d    = 1'b0;
      illegal_d = 1'b0;
    end

    if (load_addr) begin
      addr_d = addr_in;
    end else if (complete) begin
      addr_d = addr_q + ADDR_W'(4);
    end

    if (complete && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q    <= 1'b0;
      illegal_q <= 1'b0;
      word_q    <= 32'd0;
      addr_q    <= ADDR_W'(BASE_ADDR);
      count_q   <= 16'd0;
    end else begin
      full_q    <= full_d;
      illegal_q <= illegal_d;
      word_q    <= word_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
    end
  end

  assign req.in_ready   = ready;
  assign mem_we         = full_q && !illegal_q;
  assign err            = full_q && illegal_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = word_q;
  assign words_written  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_inst_encoder : directed bench for inst_encoder (ADDR_W=12 and ADDR_W=8)
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_ready = 1'b1;
  logic        load_addr = 1'b0;
  logic [11:0] addr_in = 12'd0;

  logic        s_valid = 1'b0;
  logic [2:0]  s_fmt = 3'd0;
  logic [4:0]  s_opc = 5'd0, s_rd = 5'd0, s_rs1 = 5'd0, s_rs2 = 5'd0;
  logic [2:0]  s_f3 = 3'd0;
  logic [6:0]  s_f7 = 7'd0;
  logic [31:0] s_imm = 32'd0;

  logic        we12, err12, we8, err8;
  logic [11:0] addr12;
  logic [7:0]  addr8;
  logic [31:0] wd12, wd8;
  logic [15:0] ww12, ww8;

  int errors = 0;
  int checks = 0;
  int err_seen = 0;
  logic [43:0] log12[$];
  logic [43:0] log8[$];

  inst_encoder_if if12 ();
  inst_encoder_if if8 ();

  assign if12.in_valid = s_valid;   assign if8.in_valid = s_valid;
  assign if12.in_fmt = s_fmt;       assign if8.in_fmt = s_fmt;
  assign if12.in_opcode = s_opc;    assign if8.in_opcode = s_opc;
  assign if12.in_rd = s_rd;         assign if8.in_rd = s_rd;
  assign if12.in_rs1 = s_rs1;       assign if8.in_rs1 = s_rs1;
  assign if12.in_rs2 = s_rs2;       assign if8.in_rs2 = s_rs2;
  assign if12.in_funct3 = s_f3;     assign if8.in_funct3 = s_f3;
  assign if12.in_funct7 = s_f7;     assign if8.in_funct7 = s_f7;
  assign if12.in_imm = s_imm;       assign if8.in_imm = s_imm;

  inst_encoder #(.ADDR_W(12), .BASE_ADDR(0)) dut12 (
    .clk(clk), .reset(reset), .req(if12.slave), .load_addr(load_addr),
    .addr_in(addr_in), .mem_we(we12), .mem_ready(mem_ready), .mem_addr(addr12),
    .mem_wdata(wd12), .err(err12), .words_written(ww12)
  );

  inst_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut8 (
    .clk(clk), .reset(reset), .req(if8.slave), .load_addr(load_addr),
    .addr_in(addr_in[7:0]), .mem_we(we8), .mem_ready(mem_ready), .mem_addr(addr8),
    .mem_wdata(wd8), .err(err8), .words_written(ww8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [43:0] act, input logic [43:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference encoding built from field positions by arithmetic.
  function automatic logic [31:0] ref_word(input logic [2:0] f, input logic [31:0] opc,
      input logic [31:0] rd, input logic [31:0] rs1, input logic [31:0] rs2,
      input logic [31:0] f3, input logic [31:0] f7, input logic [31:0] imm);
    logic [31:0] op, regs;
    op   = opc * 4 + 3;
    regs = (rs1 << 15) | (f3 << 12);
    case (f)
      3'd0: return (imm & 32'hFFFF_F000) | (rd << 7) | op;
      3'd1: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                 | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                 | (rd << 7) | op;
      3'd2: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                 | (rs2 << 20) | regs | (((imm >> 1) & 32'hF) << 8)
                 | (((imm >> 11) & 1) << 7) | op;
      3'd3: return (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | regs
                 | ((imm & 32'h1F) << 7) | op;
      3'd4: return ((imm & 32'hFFF) << 20) | regs | (rd << 7) | op;
      3'd5: return (f7 << 25) | ((imm & 32'h1F) << 20) | regs | (rd << 7) | op;
      default: return (f7 << 25) | (rs2 << 20) | regs | (rd << 7) | op;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [2:0] f, input logic [31:0] imm);
    longint s;
    s = longint'($signed(imm));
    case (f)
      3'd0: return (imm % 4096) == 0;
      3'd1: return (imm[0] == 1'b0) && (s >= -(64'sd1 <<< 20)) && (s < (64'sd1 <<< 20));
      3'd2: return (imm[0] == 1'b0) && (s >= -4096) && (s < 4096);
      3'd3, 3'd4: return (s >= -2048) && (s < 2048);
      3'd5: return imm < 32;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Behavioural model: one holding slot, checked every cycle at negedge.
  bit          m_on = 0, m_full = 0, m_ill = 0;
  logic [31:0] m_word = 32'd0;
  int unsigned m_addr = 0, m_cnt = 0;

  initial forever begin
    bit rdy, done;
    @(negedge clk);
    rdy  = !m_full || m_ill || mem_ready;
    done = m_full && !m_ill && mem_ready;
    if (m_on) begin
      chk("in_ready12", 44'(if12.in_ready), 44'(rdy));
      chk("in_ready8", 44'(if8.in_ready), 44'(rdy));
      chk("mem_we12", 44'(we12), 44'(m_full && !m_ill));
      chk("mem_we8", 44'(we8), 44'(m_full && !m_ill));
      chk("err12", 44'(err12), 44'(m_full && m_ill));
      chk("err8", 44'(err8), 44'(m_full && m_ill));
      chk("addr12", 44'(addr12), 44'(m_addr % 4096));
      chk("addr8", 44'(addr8), 44'(m_addr % 256));
      chk("words12", 44'(ww12), 44'(m_cnt));
      chk("words8", 44'(ww8), 44'(m_cnt));
      if (m_full && !m_ill) begin
        chk("wdata12", 44'(wd12), 44'(m_word));
        chk("wdata8", 44'(wd8), 44'(m_word));
      end
    end
    if (err12 === 1'b1) err_seen++;
    if (we12 === 1'b1 && mem_ready) log12.push_back({addr12, wd12});
    if (we8 === 1'b1 && mem_ready) log8.push_back({4'd0, addr8, wd8});

    if (reset) begin
      m_on = 1; m_full = 0; m_ill = 0; m_word = 32'd0; m_addr = 0; m_cnt = 0;
    end else if (m_on) begin
      // The model address is kept wide; each DUT view reduces it modulo its own width.
      if (load_addr) m_addr = (m_addr & ~32'hFFF) | addr_in;
      else if (done) m_addr = m_addr + 4;
      if (load_addr) m_addr = addr_in;
      if (done && m_cnt < 16'hFFFF) m_cnt++;
      if (s_valid && rdy) begin
        m_full = 1;
        m_ill  = !ref_legal(s_fmt, s_imm);
        m_word = ref_word(s_fmt, 32'(s_opc), 32'(s_rd), 32'(s_rs1), 32'(s_rs2),
                          32'(s_f3), 32'(s_f7), s_imm);
      end else if (done || m_ill) begin
        m_full = 0;
        m_ill  = 0;
      end
    end
  end

  task automatic send(input logic [2:0] f, input logic [4:0] opc, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    bit taken = 0;
    s_fmt = f; s_opc = opc; s_rd = rd; s_rs1 = rs1; s_rs2 = rs2;
    s_f3 = f3; s_f7 = f7; s_imm = imm; s_valid = 1'b1;
    for (int i = 0; i < 20 && !taken; i++) begin
      @(negedge clk);
      taken = (if12.in_ready === 1'b1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    if (!taken) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: request not accepted within 20 cycles, want accepted");
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] W_ADDI = 32'h0050_0093;
  localparam logic [31:0] W_LUI  = 32'h1234_52B7;
  localparam logic [31:0] W_JAL  = 32'h0080_00EF;
  localparam logic [31:0] W_BEQ  = 32'hFE20_8EE3;
  localparam logic [31:0] W_SRAI = 32'h4031_5113;

  task automatic s_addi(); send(3'd4, OP_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5); endtask
  task automatic s_lui();  send(3'd0, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000); endtask
  task automatic s_jal();  send(3'd1, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8); endtask
  task automatic s_beq();  send(3'd2, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC); endtask
  task automatic s_srai(); send(3'd5, OP_OPIMM, 5'd2, 5'd2, 5'd0, 3'b101, 7'b0100000, 32'd3); endtask

  initial begin
    do_reset();
    chk("rst_wdata", 44'(wd12), 44'd0);
    chk("rst_ready", 44'(if12.in_ready), 44'd1);
    chk("rst_addr", 44'(addr12), 44'd0);
    chk("rst_words", 44'(ww12), 44'd0);
    chk("model_addi", 44'(ref_word(3'd4, 32'(OP_OPIMM), 1, 0, 0, 0, 0, 5)), 44'(W_ADDI));
    chk("model_beq", 44'(ref_word(3'd2, 32'(OP_BRANCH), 0, 1, 2, 0, 0, 32'hFFFF_FFFC)), 44'(W_BEQ));

    s_addi();
    idle(1);
    chk("addi_log", log12[0], {12'h000, W_ADDI});
    chk("addi_addr", 44'(addr12), 44'h004);
    chk("addi_words", 44'(ww12), 44'd1);

    s_lui(); s_jal(); s_beq(); s_srai();
    idle(1);
    chk("seq_lui", log12[1], {12'h004, W_LUI});
    chk("seq_jal", log12[2], {12'h008, W_JAL});
    chk("seq_beq", log12[3], {12'h00C, W_BEQ});
    chk("seq_srai", log12[4], {12'h010, W_SRAI});

    send(3'd4, OP_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    send(3'd2, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    send(3'd7, OP_OP, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    idle(2);
    chk("illegal_errs", 44'(err_seen), 44'd3);
    chk("illegal_addr", 44'(addr12), 44'h014);
    chk("illegal_words", 44'(ww12), 44'd5);

    do_reset();
    log12.delete(); log8.delete();
    mem_ready = 1'b0;
    s_addi();
    fork
      s_lui();
      begin idle(3); mem_ready = 1'b1; end
    join
    idle(3);
    chk("bp_count", 44'(log12.size()), 44'd2);
    chk("bp_first", log12[0], {12'h000, W_ADDI});
    chk("bp_second", log12[1], {12'h004, W_LUI});
    chk("bp_words", 44'(ww12), 44'd2);

    log12.delete(); log8.delete();
    addr_in = 12'h0FC; load_addr = 1'b1;
    idle(1);
    load_addr = 1'b0;
    s_jal(); s_beq();
    s_srai();
    addr_in = 12'h040; load_addr = 1'b1;
    idle(1);
    load_addr = 1'b0;
    s_addi();
    idle(2);
    chk("wrap8_a", log8[0], {12'h0FC, W_JAL});
    chk("wrap8_b", log8[1], {12'h000, W_BEQ});
    chk("wrap12_b", log12[1], {12'h100, W_BEQ});
    chk("load_old", log8[2], {12'h004, W_SRAI});
    chk("load_new", log8[3], {12'h040, W_ADDI});

    mem_ready = 1'b0;
    s_lui();
    chk("held_we", 44'(we12), 44'd1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("rstw_we", 44'(we12), 44'd0);
    chk("rstw_addr", 44'(addr12), 44'd0);
    chk("rstw_words", 44'(ww12), 44'd0);
    chk("rstw_ready", 44'(if12.in_ready), 44'd1);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_encoder.md
# inst_encoder

Instruction encoder and program writer, the inverse of the decode-side immediate builder. It accepts decoded instruction fields (format, opcode, registers, funct bits, full 32-bit immediate) over a valid/ready handshake. It range-checks the immediate, packs the RV32I instruction word and writes it into instruction memory at an auto-incrementing byte address. Used by the boot/program loader and by self-test sequences to fill instruction RAM.

## Interface
- ADDR_W, 12: instruction-memory byte address width.
- BASE_ADDR, 0: address counter value after reset.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept the request this cycle.
- in_fmt  in  3  format code: U=0, J=1, B=2, S=3, I=4, ISH=5 (shift-immediate), R=6; 7 is invalid.
- in_opcode  in  5  inst[6:2]; encoder appends inst[1:0]=2'b11.
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_funct3  in  3; in_funct7  in  7  (R and ISH only).
- in_imm  in  32  immediate as the decoder would reconstruct it (sign-extended / shifted).
- load_addr  in  1  load write address from addr_in.
- addr_in  in  ADDR_W  new write address.
- mem_we  out  1  write request.
- mem_ready  in  1  memory accepts the write this cycle.
- mem_addr  out  ADDR_W  byte address of the current write.
- mem_wdata  out  32  packed instruction.
- err  out  1  one-cycle pulse: a request was dropped for an illegal immediate or format.
- words_written  out  16  count of completed writes, saturating at 0xFFFF.

## Operation
- Packing, op = {in_opcode, 2'b11}:
  - U: {imm[31:12], rd, op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - I: {imm[11:0], rs1, f3, rd, op}.
  - ISH: {f7, imm[4:0], rs1, f3, rd, op}.
  - R: {f7, rs2, rs1, f3, rd, op}; imm ignored.
- Legality checks; any failure marks the request illegal:
  - U: imm[11:0]==0.
  - J: imm[0]==0, and imm[31:21] all equal imm[20].
  - B: imm[0]==0, and imm[31:13] all equal imm[12].
  - S and I: imm[31:12] all equal imm[11].
  - ISH: imm[31:5]==0.
  - fmt 7: always illegal.
- Single holding stage (full flag, word, illegal flag):
  - A request is accepted when in_valid && in_ready.
  - in_ready = !full || (full && (illegal || mem_ready)).
- Output port: mem_we = full && !illegal.
- Write completion: mem_we && mem_ready. On completion:
  - mem_addr += 4, wrapping modulo 2^ADDR_W.
  - words_written increments.
  - The stage empties, unless a new request is accepted in the same cycle.
- Illegal request: it sits in the stage for one cycle with err=1 and mem_we=0, then is discarded. Address and count are unchanged.
- load_addr: mem_addr <= addr_in. If a write completes in the same cycle, that write uses the old address and load_addr overrides the increment.
- Reset: full=0, err=0, mem_we=0, mem_wdata=0, mem_addr=BASE_ADDR, words_written=0, in_ready=1. Reset mid-write drops the held word.

## Timing
- Latency: a request accepted at edge N gives mem_we=1 with the packed word during cycle N+1.
- Throughput: one word per cycle while mem_ready stays high.
- in_ready depends combinationally on mem_ready; no other combinational input-to-output paths.
- mem_addr, mem_wdata and mem_we are stable while mem_we=1 and mem_ready=0.
- err is high exactly one cycle per illegal request. Back-to-back illegal requests give consecutive err pulses.

## Structure
- Shared package: format codes (FMT_U … FMT_R), opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_OPIMM, OP_OP), and the 7-bit encoding helper.
- Sub-module inst_packer: purely combinational, maps fields + imm to {word, illegal}. The top level holds the stage, address counter, word counter and handshake.

## Test plan
- addi x1,x0,5 (I, op 00100, rd=1, imm=5) at address 0 -> mem_wdata=0x00500093, mem_addr=0x000, next addr 0x004, words_written=1.
- Sequential words, one per cycle:
  - lui x5,0x12345000 -> 0x123452B7.
  - jal x1,+8 -> 0x008000EF.
  - beq x1,x2,-4 -> 0xFE208EE3.
  - srai x2,x2,3 (f7=0100000, f3=101) -> 0x40315113.
- I with imm=2048, and B with imm=3 -> one err pulse each, mem_we stays 0, mem_addr and words_written unchanged.
- Backpressure: mem_ready low 3 cycles, two requests -> in_ready drops after the first accept; no duplicate or lost word; writes go to 0x000 then 0x004 in order.
- ADDR_W=8: load_addr to 0xFC, write two words -> addresses 0xFC then 0x00. load_addr with addr_in=0x40 during a completing write -> that write uses the old address, the next write goes to 0x40.
- Reset asserted with a word held and mem_ready low -> next cycle mem_we=0, mem_addr=BASE_ADDR, words_written=0, in_ready=1.
